// File: rtl/sdram_arbiter.sv
// SDRAM command-bus arbiter: passes the init sequencer through until init completes,
// then grants the pins to one of auto-refresh, write or read at a time.
module sdram_arbiter #(
  parameter logic [3:0]  NOP_CMD   = 4'b0111,
  parameter logic [12:0] IDLE_ADDR = 13'h1FFF,
  parameter logic [1:0]  IDLE_BA   = 2'b11
) (
  input  logic        clk_100M,
  input  logic        locked_rst_n,
  input  logic [3:0]  init_cmd,
  input  logic [12:0] init_addr,
  input  logic [1:0]  init_bank_addr,
  input  logic        init_end,
  input  logic        aref_req,
  input  logic [3:0]  aref_cmd,
  input  logic [12:0] aref_addr,
  input  logic [1:0]  aref_bank_addr,
  input  logic        aref_end,
  input  logic        wr_req,
  input  logic [3:0]  wr_cmd,
  input  logic [12:0] wr_addr,
  input  logic [1:0]  wr_bank_addr,
  input  logic        wr_end,
  input  logic [15:0] wr_data,
  input  logic        wr_sdram_en,
  input  logic        rd_req,
  input  logic [3:0]  rd_cmd,
  input  logic [12:0] rd_addr,
  input  logic [1:0]  rd_bank_addr,
  input  logic        rd_end,
  output logic        aref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_ba,
  output logic [12:0] sdram_addr,
  output logic [15:0] sdram_dq_out,
  output logic        sdram_dq_oe
);

  typedef enum logic [2:0] {StInit, StArbit, StAref, StWrite, StRead} state_e;

  state_e      state_q, state_d;
  logic        last_wr_q, last_wr_d;
  logic        aref_en_q, wr_en_q, rd_en_q;
  logic [3:0]  cmd_mux;
  logic [12:0] addr_mux;
  logic [1:0]  ba_mux;

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    unique case (state_q)
      StInit: if (init_end) state_d = StArbit;
      StArbit: begin
        // Refresh first; on a write/read tie, last_wr picks the one not served last.
        if (aref_req) begin
          state_d = StAref;
        end else if (wr_req && (!rd_req || !last_wr_q)) begin
          state_d   = StWrite;
          last_wr_d = 1'b1;
        end else if (rd_req) begin
          state_d   = StRead;
          last_wr_d = 1'b0;
        end
      end
      StAref:  if (aref_end) state_d = StArbit;
      StWrite: if (wr_end)   state_d = StArbit;
      StRead:  if (rd_end)   state_d = StArbit;
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk_100M or negedge locked_rst_n) begin
    if (!locked_rst_n) begin
      state_q   <= StInit;
      last_wr_q <= 1'b0;
      aref_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      aref_en_q <= (state_d == StAref);
      wr_en_q   <= (state_d == StWrite);
      rd_en_q   <= (state_d == StRead);
    end
  end

  always_comb begin
    cmd_mux  = NOP_CMD;
    addr_mux = IDLE_ADDR;
    ba_mux   = IDLE_BA;
    unique case (state_q)
      StInit: begin
        cmd_mux  = init_cmd;
        addr_mux = init_addr;
        ba_mux   = init_bank_addr;
      end
      StAref: begin
        cmd_mux  = aref_cmd;
        addr_mux = aref_addr;
        ba_mux   = aref_bank_addr;
      end
      StWrite: begin
        cmd_mux  = wr_cmd;
        addr_mux = wr_addr;
        ba_mux   = wr_bank_addr;
      end
      StRead: begin
        cmd_mux  = rd_cmd;
        addr_mux = rd_addr;
        ba_mux   = rd_bank_addr;
      end
      default: ;
    endcase
  end

  assign aref_en      = aref_en_q;
  assign wr_en        = wr_en_q;
  assign rd_en        = rd_en_q;
  assign sdram_cke    = 1'b1;
  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_mux;
  assign sdram_ba     = ba_mux;
  assign sdram_addr   = addr_mux;
  assign sdram_dq_out = wr_data;
  assign sdram_dq_oe  = (state_q == StWrite) && wr_sdram_en;

endmodule
